// File: rtl/imem_fetch_unit_pkg.sv
// Shared widths and the {pc, inst} fetch-buffer entry type for the instruction-fetch unit.
package imem_fetch_unit_pkg;
  localparam int IMEM_ADDR_W = 30;
  localparam int INST_W      = 32;
  localparam int FB_DEPTH    = 2;
  localparam int FB_ENTRY_W  = 64;
  localparam int FB_CNT_W    = 2;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fb_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Small shift-style FIFO of {pc, inst} entries; head is always entry 0.
module fetch_skid_buf
  import imem_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  fb_entry_t           push_data,
  output fb_entry_t           head,
  output logic [FB_CNT_W-1:0] count
);
  fb_entry_t mem [FB_DEPTH];
  logic [FB_CNT_W-1:0] wr_idx;

  // After a same-cycle pop the write slot moves down by one.
  assign wr_idx = count - FB_CNT_W'(pop);
  assign head   = mem[0];

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else              count <= count + FB_CNT_W'(push) - FB_CNT_W'(pop);
  end

  for (genvar i = 0; i < FB_DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (push && wr_idx == FB_CNT_W'(i)) begin
        mem[i] <= push_data;
      end else if (pop) begin
        if (i + 1 < FB_DEPTH) mem[i] <= mem[(i + 1) % FB_DEPTH];
      end
    end
  end
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch requester: hides the ROM's 1-cycle latency and streams {pc, inst} to decode.
// Optional FETCH_PERF_CNT_EN adds pop/stall performance counters.
module imem_fetch_unit
  import imem_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall,
`endif
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]      imem_inst,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [31:0]            if_pc,
  output logic [INST_W-1:0]      if_inst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc
);
  logic [31:0]         pc_q, infl_pc_q, redir_pc;
  logic                infl_q;
  logic [FB_CNT_W-1:0] count;
  logic [2:0]          credit;
  logic                pop, push, buf_pop, issue, buf_empty;
  fb_entry_t           buf_head, bypass, head;

  assign redir_pc  = redirect_pc & ~32'h3;
  assign buf_empty = (count == '0);
  assign bypass    = '{pc: infl_pc_q, inst: imem_inst};
  assign head      = buf_empty ? bypass : buf_head;

  assign if_valid = !rst && !redirect_valid && (!buf_empty || infl_q);
  assign pop      = if_valid && if_ready;
  assign buf_pop  = pop && !buf_empty;
  // Returning ROM data goes to the buffer unless it leaves immediately via bypass.
  assign push     = infl_q && !rst && !redirect_valid && !(pop && buf_empty);

  // Entries that will still be held after this edge, ignoring the new request.
  assign credit = {1'b0, count} + {2'b0, infl_q} - {2'b0, pop};
  assign issue  = !rst && !redirect_valid && (credit <= 3'd1);

  always_comb begin
    imem_addr = pc_q[31:2];
    if (rst)                 imem_addr = RESET_PC[31:2];
    else if (redirect_valid) imem_addr = redir_pc[31:2];
  end

  assign if_pc   = rst ? '0 : head.pc;
  assign if_inst = rst ? '0 : head.inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC & ~32'h3;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else if (redirect_valid) begin
      infl_q    <= 1'b1;
      infl_pc_q <= redir_pc;
      pc_q      <= redir_pc + 32'd4;
    end else if (issue) begin
      infl_q    <= 1'b1;
      infl_pc_q <= pc_q;
      pc_q      <= pc_q + 32'd4;
    end else begin
      infl_q    <= 1'b0;
    end
  end

  fetch_skid_buf u_fb (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (buf_pop),
    .push_data (bypass),
    .head      (buf_head),
    .count     (count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall   <= perf_stall + 32'(if_valid && !if_ready);
    end
  end
`endif
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed cycle table plus a randomized run against a stream model.
module tb_imem_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, if_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr, imem_addr2;
  logic [31:0] rom_q, rom2_q;
  logic        if_valid, if_valid2;
  logic [31:0] if_pc, if_inst, if_pc2, if_inst2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

  always #5 clk = ~clk;

  imem_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .imem_addr(imem_addr), .imem_inst(rom_q),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  imem_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched2), .perf_stall(perf_stall2),
`endif
    .imem_addr(imem_addr2), .imem_inst(rom2_q),
    .if_valid(if_valid2), .if_ready(if_ready), .if_pc(if_pc2), .if_inst(if_inst2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    logic [31:0] img [5];
    img = '{32'h3c1d1000, 32'h0c000003, 32'h37bd0100, 32'h27bdffe0, 32'hafbe0018};
    if (a < 30'd5) return img[a[2:0]];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Registered-address ROMs
  always @(posedge clk) begin
    rom_q  <= rom_word(imem_addr);
    rom2_q <= rom_word(imem_addr2);
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: accepted instructions form a PC sequence restarted by reset/redirect.
  logic [31:0] exp_pc = 32'h0;
  logic        prev_rst = 1'b1, prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_inst;
  int          m_fetched = 0, m_stall = 0;

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic ev;
    @(negedge clk);
    rst = r; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    ev = !r && !rv && !prev_rst;
    chk("model_valid", {31'b0, if_valid}, {31'b0, ev});
    if (r) begin
      chk("rst_addr", {2'b0, imem_addr}, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
    end else if (rv) begin
      chk("redir_addr", {2'b0, imem_addr}, {2'b0, rpc[31:2]});
    end
    if (if_valid && rdy) begin
      chk("model_pc", if_pc, exp_pc);
      chk("model_inst", if_inst, rom_word(exp_pc[31:2]));
    end
    if (prev_stall && !r && !rv) begin
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_inst", if_inst, prev_inst);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_stall", perf_stall, 32'(m_stall));
    if (r) begin
      m_fetched = 0; m_stall = 0;
    end else begin
      m_fetched += int'(if_valid && rdy);
      m_stall   += int'(if_valid && !rdy);
    end
`endif
    prev_stall = if_valid && !rdy;
    prev_pc    = if_pc;
    prev_inst  = if_inst;
    if (r)                    exp_pc = 32'h0;
    else if (rv)              exp_pc = rpc & ~32'h3;
    else if (if_valid && rdy) exp_pc = exp_pc + 32'd4;
    prev_rst = r;
  endtask

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einst;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v = '{rst: r, rdy: rdy, rv: rv, rpc: rpc, ev: ev, epc: epc, einst: einst};
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    // reset, then stream 0,4
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h0, 32'h3c1d1000);
    add(0, 1, 0, 0, 1, 32'h4, 32'h0c000003);
    // 5-cycle stall on pc 8, then release
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 32'h8, 32'h37bd0100);
    add(0, 1, 0, 0, 1, 32'h8,  32'h37bd0100);
    add(0, 1, 0, 0, 1, 32'hC,  32'h27bdffe0);
    add(0, 1, 0, 0, 1, 32'h10, 32'hafbe0018);
    add(0, 1, 0, 0, 1, 32'h14, 32'h0005FFFA);
    // redirect to 0xC, then to 0xE (low bits dropped)
    add(0, 1, 1, 32'hC, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'hC,  32'h27bdffe0);
    add(0, 1, 0, 0, 1, 32'h10, 32'hafbe0018);
    add(0, 1, 1, 32'hE, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'hC,  32'h27bdffe0);
    add(0, 1, 0, 0, 1, 32'h10, 32'hafbe0018);
    // fill buffer under stall, then reset mid-stall
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 32'h14, 32'h0005FFFA);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h0, 32'h3c1d1000);
    add(0, 1, 0, 0, 1, 32'h4, 32'h0c000003);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_inst", i), if_inst, tbl[i].einst);
      end
      // second instance starts near the top of the address space
      if (i < 3) chk("wrap_rst_addr", {2'b0, imem_addr2}, 32'h3FFFFFFF);
      if (i == 3) chk("wrap_first_valid", {31'b0, if_valid2}, 32'h0);
      if (i == 4) begin
        chk("wrap_pc0", if_pc2, 32'hFFFFFFFC);
        chk("wrap_inst0", if_inst2, {16'hFFFF, 16'h0000});
      end
      if (i == 5) begin
        chk("wrap_pc1", if_pc2, 32'h0);
        chk("wrap_inst1", if_inst2, 32'h3c1d1000);
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 11) begin
        chk("stall_after_s2", perf_stall, 32'd5);
        chk("fetched_after_s2", perf_fetched, 32'd2);
      end
`endif
    end

    for (int i = 0; i < 800; i++) begin
      logic        r, rdy, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 127));
      step(r, rdy, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
